secuenciador_clave: RTL and testbench
=====================================

# secuenciador_clave

Bus-master controller that drives the keypad security core at CORE_ADDR through its full verification sequence.
- On each `start` request it issues four commands, then evaluates the result: load high half of reference key, load low half, query match, read/clear accumulator status.
- Manages a failed-attempt counter with timed lockout, a timed unlock output, and a bus watchdog.
- Sits between the processor-side start/reference-key registers and the security peripheral's `addr/data_i/en/cmd/isDone/data_o` port.

## Interface
- CORE_ADDR, 'h16, bus address of the security core.
- MAX_INTENTOS, 3, consecutive mismatches before lockout (≥1).
- OPEN_CYCLES, 50_000_000, cycles `abierto` stays high after a match.
- LOCKOUT_CYCLES, 500_000_000, cycles spent locked.
- TIMEOUT, 255, maximum cycles to wait for `isDone_i` per command.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a verification; level-sampled in IDLE/FAULT only.
- clave_ref  in  32  reference key; sampled on `start` acceptance.
- addr_o  out  16  constant CORE_ADDR.
- cmd_o  out  4  command to core: 1=CLAVE_H, 2=CLAVE_L, 3=COINCIDEN, 4=INFORMAR; 0 when idle.
- data_o  out  16  operand for CLAVE_H/CLAVE_L, 0 otherwise.
- en_o  out  1  transaction request.
- isDone_i  in  1  core completion.
- data_i  in  16  core read data.
- abierto  out  1  unlock, high for OPEN_CYCLES.
- bloqueado  out  1  high during lockout.
- error  out  1  sticky bus timeout flag.
- busy  out  1  high whenever state ≠ IDLE.
- intentos  out  $clog2(MAX_INTENTOS+1)  current failed-attempt count.
- estado_core  out  3  last INFORMAR result, `data_i[2:0]`.

## Operation

**States:** IDLE, ISSUE, GAP, EVAL, OPEN, LOCKED, FAULT.

**Reset:** all outputs 0 except `addr_o`=CORE_ADDR. State IDLE, command index 0, latched key 0, counters 0.

**IDLE**
- `start`=1: latch `clave_ref`, index←0, go to ISSUE.

**ISSUE**
- `en_o`=1, `cmd_o`=index+1, `data_o` per command.
- CLAVE_H sends key[31:16]; CLAVE_L sends key[15:0].
- Watchdog increments every cycle.
- `isDone_i`=1: capture read data, go to GAP.
  - COINCIDEN: `match`←`data_i[0]`.
  - INFORMAR: `estado_core`←`data_i[2:0]`.
- Watchdog reaches TIMEOUT: go to FAULT, `error`←1.

**GAP**
- `en_o`=0 and `cmd_o`=0 for exactly one cycle; watchdog cleared.
- index<3: index++, go to ISSUE. Otherwise go to EVAL.

**EVAL** (one cycle)
- `match`=1: `intentos`←0, go to OPEN.
- Otherwise: `intentos`++ (saturating at MAX_INTENTOS).
  - New value = MAX_INTENTOS: go to LOCKED.
  - Else go to IDLE.

**OPEN**
- `abierto`=1 for OPEN_CYCLES, then go to IDLE.

**LOCKED**
- `bloqueado`=1 for LOCKOUT_CYCLES; then `intentos`←0, go to IDLE.

**FAULT**
- `en_o`=0; `error` stays 1.
- `start`=1: clear `error`, go to IDLE. No sequence is started on that edge.

**Boundary rules**
- `start` is ignored in ISSUE, GAP, EVAL, OPEN and LOCKED.
- `isDone_i` is ignored while `en_o`=0.
- A reset asserted mid-transaction drops `en_o` asynchronously; the sequence is abandoned and the attempt is not counted.
- `clave_ref` changes after acceptance do not affect the running sequence.

## Timing
- `start` sampled at edge N → `en_o`=1 with CLAVE_H from N+1.
- With `isDone_i` returned in the first cycle of each request, each command costs ISSUE 1 + GAP 1 = 2 cycles.
- EVAL follows the last GAP; `abierto`/`bloqueado` rise at N+10.
- Every command holds `en_o`/`cmd_o`/`data_o` stable until the edge where `isDone_i`=1 is sampled.
- Timeout: `en_o` falls at the edge after TIMEOUT ISSUE cycles without `isDone_i`.
- All outputs are registered.

## Structure
- Shared package `seguridad_pkg`:
  - command codes CMD_CLAVE_H=1, CMD_CLAVE_L=2, CMD_COINCIDEN=3, CMD_INFORMAR=4;
  - CORE_ADDR default;
  - state encoding.
- One sub-module `contador_espera`: loadable down-counter with a `cero` flag. A single instance is shared by watchdog, OPEN and LOCKED timing, which are mutually exclusive. Width 32.

## Test plan
Bench parameters for all scenarios: TIMEOUT=8, OPEN_CYCLES=4, LOCKOUT_CYCLES=10, MAX_INTENTOS=3.

1. `clave_ref`=32'h1234ABCD, core model replies `isDone` after 1 cycle, COINCIDEN `data_i`=1 → `cmd_o` sequence 1,2,3,4; `data_o` 16'h1234 then 16'hABCD; `abierto` high exactly 4 cycles; `intentos`=0.
2. COINCIDEN returns 0 three times → `intentos` 1,2,3; `bloqueado` high 10 cycles; `start` during lockout is ignored; `intentos`=0 afterwards.
3. Core never asserts `isDone` on CLAVE_L → `en_o` falls after 8 cycles; `error`=1, `busy`=1; a `start` pulse returns IDLE with `error`=0.
4. INFORMAR returns `data_i`=16'h0005 → `estado_core`=3'b101.
5. Reset asserted during the CLAVE_L request → `en_o`=0 immediately; all outputs at reset values; `intentos` unchanged from 0.
6. Core delays `isDone` 5 cycles per command → `en_o`/`cmd_o`/`data_o` stable throughout; each GAP is exactly 1 cycle with `en_o`=0.

Source files
------------

// File: rtl/seguridad_pkg.sv
// Shared definitions for the keypad security sequencer: core command codes,
// default bus address, FSM state encoding and the index-to-command mapping.
package seguridad_pkg;

    localparam logic [15:0] CORE_ADDR_DEF = 16'h0016;

    localparam logic [3:0] CMD_NINGUNO   = 4'd0;
    localparam logic [3:0] CMD_CLAVE_H   = 4'd1;
    localparam logic [3:0] CMD_CLAVE_L   = 4'd2;
    localparam logic [3:0] CMD_COINCIDEN = 4'd3;
    localparam logic [3:0] CMD_INFORMAR  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_EVAL,
        ST_OPEN,
        ST_LOCKED,
        ST_FAULT
    } estado_t;

    function automatic logic [3:0] cmd_de_indice(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_CLAVE_H;
            2'd1:    return CMD_CLAVE_L;
            2'd2:    return CMD_COINCIDEN;
            default: return CMD_INFORMAR;
        endcase
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Loadable down-counter that stops at zero; o_cero is high while the count is 0.
// Load has priority over decrement; one cycle from load to the new value.
module contador_espera #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cargar,
    input  logic [W-1:0] i_valor,
    input  logic         i_dec,
    output logic         o_cero
);

    logic [W-1:0] r_cuenta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cuenta <= '0;
        end else if (i_cargar) begin
            r_cuenta <= i_valor;
        end else if (i_dec && (r_cuenta != '0)) begin
            r_cuenta <= r_cuenta - W'(1);
        end
    end

    assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/secuenciador_clave.sv
// Bus master that walks the security core through CLAVE_H, CLAVE_L, COINCIDEN, INFORMAR,
// then opens, counts a failure or locks out. All outputs registered; 2 cycles per command minimum.
module secuenciador_clave
    import seguridad_pkg::*;
#(
    parameter logic [15:0] CORE_ADDR      = CORE_ADDR_DEF,
    parameter int unsigned MAX_INTENTOS   = 3,
    parameter int unsigned OPEN_CYCLES    = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [31:0]                         clave_ref,
    output logic [15:0]                         addr_o,
    output logic [3:0]                          cmd_o,
    output logic [15:0]                         data_o,
    output logic                                en_o,
    input  logic                                isDone_i,
    input  logic [15:0]                         data_i,
    output logic                                abierto,
    output logic                                bloqueado,
    output logic                                error,
    output logic                                busy,
    output logic [$clog2(MAX_INTENTOS+1)-1:0]   intentos,
    output logic [2:0]                          estado_core
);

    localparam int          W_INT      = $clog2(MAX_INTENTOS + 1);
    localparam logic [W_INT-1:0] MAX_V = W_INT'(MAX_INTENTOS);
    localparam logic [31:0] CARGA_WD   = 32'(TIMEOUT - 1);
    localparam logic [31:0] CARGA_OPEN = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] CARGA_LOCK = 32'(LOCKOUT_CYCLES - 1);

    estado_t            r_estado;
    logic [1:0]         r_idx;
    logic [31:0]        r_clave;
    logic               r_match;

    estado_t            w_sig_estado;
    logic [1:0]         w_sig_idx;
    logic [31:0]        w_sig_clave;
    logic               w_sig_match;
    logic [W_INT-1:0]   w_sig_intentos;
    logic [W_INT-1:0]   w_inc;
    logic [2:0]         w_sig_estado_core;
    logic               w_sig_error;
    logic [15:0]        w_sig_dato;
    logic               w_cargar;
    logic [31:0]        w_valor;
    logic               w_dec;
    logic               w_cero;
    logic               w_unused_datos;

    assign addr_o         = CORE_ADDR;
    assign w_unused_datos = &{1'b0, data_i[15:3]};

    contador_espera #(.W(32)) u_contador (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_cargar (w_cargar),
        .i_valor  (w_valor),
        .i_dec    (w_dec),
        .o_cero   (w_cero)
    );

    always_comb begin
        w_sig_estado      = r_estado;
        w_sig_idx         = r_idx;
        w_sig_clave       = r_clave;
        w_sig_match       = r_match;
        w_sig_intentos    = intentos;
        w_sig_estado_core = estado_core;
        w_sig_error       = error;
        w_cargar          = 1'b0;
        w_valor           = '0;
        w_dec             = 1'b0;
        w_inc             = (intentos == MAX_V) ? MAX_V : intentos + W_INT'(1);

        case (r_estado)
            ST_IDLE: begin
                if (start) begin
                    w_sig_clave  = clave_ref;
                    w_sig_idx    = 2'd0;
                    w_sig_match  = 1'b0;
                    w_sig_estado = ST_ISSUE;
                    w_cargar     = 1'b1;
                    w_valor      = CARGA_WD;
                end
            end
            ST_ISSUE: begin
                if (isDone_i) begin
                    if (r_idx == 2'd2) w_sig_match       = data_i[0];
                    if (r_idx == 2'd3) w_sig_estado_core = data_i[2:0];
                    w_sig_estado = ST_GAP;
                end else if (w_cero) begin
                    w_sig_estado = ST_FAULT;
                    w_sig_error  = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_idx != 2'd3) begin
                    w_sig_idx    = r_idx + 2'd1;
                    w_sig_estado = ST_ISSUE;
                    w_cargar     = 1'b1;
                    w_valor      = CARGA_WD;
                end else begin
                    w_sig_estado = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (r_match) begin
                    w_sig_intentos = '0;
                    w_sig_estado   = ST_OPEN;
                    w_cargar       = 1'b1;
                    w_valor        = CARGA_OPEN;
                end else begin
                    w_sig_intentos = w_inc;
                    if (w_inc == MAX_V) begin
                        w_sig_estado = ST_LOCKED;
                        w_cargar     = 1'b1;
                        w_valor      = CARGA_LOCK;
                    end else begin
                        w_sig_estado = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                if (w_cero) w_sig_estado = ST_IDLE;
                else        w_dec        = 1'b1;
            end
            ST_LOCKED: begin
                if (w_cero) begin
                    w_sig_intentos = '0;
                    w_sig_estado   = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_FAULT: begin
                // Leaving FAULT only clears the flag; a new sequence needs a fresh start.
                if (start) begin
                    w_sig_error  = 1'b0;
                    w_sig_estado = ST_IDLE;
                end
            end
            default: w_sig_estado = ST_IDLE;
        endcase

        w_sig_dato = '0;
        if (w_sig_estado == ST_ISSUE) begin
            if (w_sig_idx == 2'd0)      w_sig_dato = w_sig_clave[31:16];
            else if (w_sig_idx == 2'd1) w_sig_dato = w_sig_clave[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= ST_IDLE;
            r_idx       <= '0;
            r_clave     <= '0;
            r_match     <= 1'b0;
            intentos    <= '0;
            estado_core <= '0;
            error       <= 1'b0;
            en_o        <= 1'b0;
            cmd_o       <= CMD_NINGUNO;
            data_o      <= '0;
            abierto     <= 1'b0;
            bloqueado   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_estado    <= w_sig_estado;
            r_idx       <= w_sig_idx;
            r_clave     <= w_sig_clave;
            r_match     <= w_sig_match;
            intentos    <= w_sig_intentos;
            estado_core <= w_sig_estado_core;
            error       <= w_sig_error;
            en_o        <= (w_sig_estado == ST_ISSUE);
            cmd_o       <= (w_sig_estado == ST_ISSUE) ? cmd_de_indice(w_sig_idx) : CMD_NINGUNO;
            data_o      <= w_sig_dato;
            abierto     <= (w_sig_estado == ST_OPEN);
            bloqueado   <= (w_sig_estado == ST_LOCKED);
            busy        <= (w_sig_estado != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_secuenciador_clave.sv
// Directed bench for secuenciador_clave with a small behavioural model of the security core.
module tb_secuenciador_clave;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] clave_ref;
    logic [15:0] addr_o;
    logic [3:0]  cmd_o;
    logic [15:0] data_o;
    logic        en_o;
    logic        isDone_i = 1'b0;
    logic [15:0] data_i   = 16'h0000;
    logic        abierto, bloqueado, error, busy;
    logic [1:0]  intentos;
    logic [2:0]  estado_core;

    secuenciador_clave #(
        .CORE_ADDR      (16'h0016),
        .MAX_INTENTOS   (3),
        .OPEN_CYCLES    (4),
        .LOCKOUT_CYCLES (10),
        .TIMEOUT        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clave_ref   (clave_ref),
        .addr_o      (addr_o),
        .cmd_o       (cmd_o),
        .data_o      (data_o),
        .en_o        (en_o),
        .isDone_i    (isDone_i),
        .data_i      (data_i),
        .abierto     (abierto),
        .bloqueado   (bloqueado),
        .error       (error),
        .busy        (busy),
        .intentos    (intentos),
        .estado_core (estado_core)
    );

    always #10 clk = ~clk;

    // Core model: answers on the (retardo+1)-th cycle of a request unless the command is muted.
    int          retardo   = 0;
    logic [3:0]  cmd_mudo  = 4'hF;
    logic        match_val = 1'b1;
    logic [15:0] informe   = 16'h0000;
    int          espera    = 0;

    always @(posedge clk) begin
        #1;
        if (en_o) begin
            isDone_i = (espera == retardo) && (cmd_o != cmd_mudo);
            data_i   = (cmd_o == 4'd3) ? {15'h0, match_val} :
                       (cmd_o == 4'd4) ? informe : 16'hDEAD;
            espera++;
        end else begin
            isDone_i = 1'b0;
            data_i   = 16'h0000;
            espera   = 0;
        end
    end

    logic [3:0]  q_cmd[$];
    logic [15:0] q_dat[$];
    int          n_abierto = 0;
    int          n_bloq    = 0;

    always @(negedge clk) begin
        if (en_o && isDone_i) begin
            q_cmd.push_back(cmd_o);
            q_dat.push_back(data_o);
        end
        if (abierto)   n_abierto++;
        if (bloqueado) n_bloq++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vec++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, esp);
        end
    endtask

    task automatic pulso_start(input logic [31:0] c);
        @(negedge clk);
        clave_ref = c;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        clave_ref = 32'hFFFF_0000;
    endtask

    task automatic esperar_libre(input string tag, input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chequear(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic comprobar_reset(input string p);
        chequear({p, "_en"},        {31'h0, en_o},      32'h0);
        chequear({p, "_cmd"},       {28'h0, cmd_o},     32'h0);
        chequear({p, "_dat"},       {16'h0, data_o},    32'h0);
        chequear({p, "_addr"},      {16'h0, addr_o},    32'h16);
        chequear({p, "_abierto"},   {31'h0, abierto},   32'h0);
        chequear({p, "_bloqueado"}, {31'h0, bloqueado}, 32'h0);
        chequear({p, "_error"},     {31'h0, error},     32'h0);
        chequear({p, "_busy"},      {31'h0, busy},      32'h0);
        chequear({p, "_intentos"},  {30'h0, intentos},  32'h0);
        chequear({p, "_estado"},    {29'h0, estado_core}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int          base_q, base_ab, base_b, k, n2;
        logic [15:0] seq;
        logic        tr[$];
        int          runs_h[$], runs_l[$];
        int          cur, lowcnt, n_inest;
        logic        vista_alta, prev_en;
        logic [3:0]  prev_cmd;
        logic [15:0] prev_dat;

        reset = 1'b1; start = 1'b0; clave_ref = '0;
        informe = 16'hFFF2;
        repeat (3) @(negedge clk);
        comprobar_reset("rst");
        reset = 1'b0;
        @(negedge clk);

        // 1: successful sequence, latched key, exact open window
        base_q = q_cmd.size(); base_ab = n_abierto;
        pulso_start(32'h1234_ABCD);
        chequear("s1_en_N1",  {31'h0, en_o},    32'h1);
        chequear("s1_cmd_N1", {28'h0, cmd_o},   32'h1);
        chequear("s1_dat_N1", {16'h0, data_o},  32'h1234);
        k = 1;
        while (!abierto && k < 30) begin
            @(negedge clk);
            k++;
        end
        chequear("s1_t_abierto", k, 10);
        esperar_libre("s1_fin", 40);
        chequear("s1_n_cmd", q_cmd.size() - base_q, 4);
        if (q_cmd.size() >= base_q + 4) begin
            seq = '0;
            for (int i = 0; i < 4; i++) seq = {seq[11:0], q_cmd[base_q + i]};
            chequear("s1_cmd_seq", {16'h0, seq}, 32'h1234);
            chequear("s1_dat_h", {16'h0, q_dat[base_q]},     32'h1234);
            chequear("s1_dat_l", {16'h0, q_dat[base_q + 1]}, 32'hABCD);
            chequear("s1_dat_q", {16'h0, q_dat[base_q + 2]}, 32'h0);
        end
        chequear("s1_n_abierto", n_abierto - base_ab, 4);
        chequear("s1_intentos", {30'h0, intentos}, 32'h0);
        chequear("s1_estado_core", {29'h0, estado_core}, 32'h2);

        // 4: INFORMAR result captured
        informe = 16'h0005;
        pulso_start(32'h0BAD_F00D);
        esperar_libre("s4_fin", 40);
        chequear("s4_estado_core", {29'h0, estado_core}, 32'h5);

        // 2: three mismatches, lockout, start ignored while locked
        match_val = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            pulso_start(32'h5555_AAAA);
            esperar_libre($sformatf("s2_fin%0d", i), 40);
            chequear($sformatf("s2_intentos%0d", i), {30'h0, intentos}, i);
        end
        base_b = n_bloq;
        pulso_start(32'h5555_AAAA);
        k = 0;
        while (!bloqueado && k < 40) begin
            @(negedge clk);
            k++;
        end
        chequear("s2_bloqueado", {31'h0, bloqueado}, 32'h1);
        chequear("s2_intentos3", {30'h0, intentos}, 32'h3);
        base_q = q_cmd.size();
        pulso_start(32'h1234_ABCD);
        esperar_libre("s2_fin_bloq", 40);
        chequear("s2_n_bloq", n_bloq - base_b, 10);
        chequear("s2_intentos_fin", {30'h0, intentos}, 32'h0);
        repeat (3) @(negedge clk);
        chequear("s2_start_ignorado", q_cmd.size() - base_q, 0);
        chequear("s2_busy_ignorado", {31'h0, busy}, 32'h0);

        // 3: core never answers CLAVE_L -> watchdog fault
        match_val = 1'b1;
        cmd_mudo  = 4'd2;
        pulso_start(32'h1111_2222);
        n2 = 0; k = 0;
        while (!error && k < 40) begin
            if (en_o && cmd_o == 4'd2) n2++;
            @(negedge clk);
            k++;
        end
        chequear("s3_ciclos_clave_l", n2, 8);
        chequear("s3_error", {31'h0, error}, 32'h1);
        chequear("s3_en",    {31'h0, en_o},  32'h0);
        chequear("s3_busy",  {31'h0, busy},  32'h1);
        chequear("s3_cmd",   {28'h0, cmd_o}, 32'h0);
        chequear("s3_intentos", {30'h0, intentos}, 32'h0);
        cmd_mudo = 4'hF;
        base_q   = q_cmd.size();
        pulso_start(32'h1234_ABCD);
        chequear("s3_error_limpio", {31'h0, error}, 32'h0);
        chequear("s3_busy_limpio",  {31'h0, busy},  32'h0);
        repeat (3) @(negedge clk);
        chequear("s3_sin_secuencia", q_cmd.size() - base_q, 0);

        // 5: asynchronous reset in the middle of CLAVE_L
        pulso_start(32'hCAFE_BABE);
        k = 0;
        while (!(en_o && cmd_o == 4'd2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chequear("s5_cmd_clave_l", {28'h0, cmd_o}, 32'h2);
        #2 reset = 1'b1;
        #1 chequear("s5_en_async", {31'h0, en_o}, 32'h0);
        comprobar_reset("s5");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chequear("s5_busy_post", {31'h0, busy}, 32'h0);
        chequear("s5_intentos_post", {30'h0, intentos}, 32'h0);

        // 6: slow core, stable request and single-cycle gaps
        retardo = 5;
        pulso_start(32'h1234_ABCD);
        k = 0; n_inest = 0; prev_en = 1'b0; prev_cmd = '0; prev_dat = '0;
        while (busy && k < 100) begin
            tr.push_back(en_o);
            if (en_o && prev_en && (cmd_o != prev_cmd || data_o != prev_dat)) n_inest++;
            prev_en = en_o; prev_cmd = cmd_o; prev_dat = data_o;
            @(negedge clk);
            k++;
        end
        chequear("s6_fin", {31'h0, busy}, 32'h0);
        chequear("s6_inestable", n_inest, 0);
        cur = 0; lowcnt = 0; vista_alta = 1'b0;
        foreach (tr[i]) begin
            if (tr[i]) begin
                if (lowcnt > 0 && vista_alta) runs_l.push_back(lowcnt);
                lowcnt = 0;
                cur++;
                vista_alta = 1'b1;
            end else begin
                if (cur > 0) runs_h.push_back(cur);
                cur = 0;
                lowcnt++;
            end
        end
        if (cur > 0) runs_h.push_back(cur);
        chequear("s6_n_peticiones", runs_h.size(), 4);
        chequear("s6_n_huecos", runs_l.size(), 3);
        foreach (runs_h[i]) chequear($sformatf("s6_largo_peticion%0d", i), runs_h[i], 6);
        foreach (runs_l[i]) chequear($sformatf("s6_largo_hueco%0d", i), runs_l[i], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
